lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
- Load/store initiator sitting between the core's execute stage and the word-organised data memory.
- Accepts one load or store per handshake and decodes RV32I funct3 into a word-aligned memory request with byte enables.
- Drives a req/ack protocol to memory and returns aligned, sign- or zero-extended load data, or an error, to the core.

Parameters:
- TIMEOUT_CYC, 16, maximum REQ-state cycles waited for mem_ack; used only with LSU_TIMEOUT_EN; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents an operation
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal or timed-out access; qualified by rsp_valid
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion, may arrive in the first mem_req cycle
- mem_rdata  in  32  read word, valid when mem_ack = 1

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE, req_ready = 1 after reset release, every other output 0.
- FSM states IDLE, REQ, RESP.
- IDLE:
  - Capture the operation on req_valid && req_ready.
  - Legal and aligned -> REQ.
  - Otherwise -> RESP with rsp_err = 1; no memory access.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Alignment rules: halfword needs addr[0] = 0; word needs addr[1:0] = 0.
- REQ:
  - mem_req = 1; mem_we, mem_addr, mem_be and mem_wdata held stable until mem_ack.
  - On mem_ack -> RESP, registering extended load data.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << addr[1:0].
  - SW: 4'b1111.
  - Loads: 4'b1111.
- Store data lanes:
  - SB replicates byte 4x.
  - SH replicates halfword 2x.
  - SW passes through.
- Load extraction:
  - Select the byte/half of mem_rdata at offset addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. The core has no backpressure.
- Latency:
  - Accept edge N, mem_ack in the first REQ cycle -> rsp_valid in cycle N+2.
  - Error path -> rsp_valid in cycle N+1.
- No new request is accepted while REQ or RESP is active; req_ready = 0 in those states.
- Reset during REQ: mem_req drops asynchronously and the operation is abandoned; no rsp_valid follows.
- mem_ack outside REQ is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in REQ.
  - If TIMEOUT_CYC REQ cycles elapse without mem_ack -> RESP with rsp_err = 1, and mem_req drops.
  - mem_ack in the final counted cycle wins over the timeout.
- Undefined: REQ waits indefinitely; rsp_err arises only from misalignment or illegal funct3.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - typedef enum lsu_state_t {IDLE, REQ, RESP}.
  - Functions be_gen() and misaligned().
- One sub-module, lsu_load_align: combinational extract/extend of mem_rdata by offset and funct3, instantiated once.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF, ack in first REQ cycle -> mem_addr 0x10, mem_be 1111, mem_wdata 0xDEADBEEF, rsp_valid at accept+2, rsp_err 0.
- SB addr 0x13, data 0x000000A5 -> mem_addr 0x10, mem_be 1000, mem_wdata 0xA5A5A5A5.
- Loads with mem_rdata 0x12348056:
  - LB addr 0x21 -> rsp_rdata 0xFFFFFF80.
  - LBU addr 0x21 -> 0x00000080.
  - LH addr 0x22 -> 0x00001234.
- LW addr 0x06 -> mem_req never asserted, rsp_valid at accept+1, rsp_err 1, rsp_rdata 0.
- Stall and timeout:
  - LW addr 0x40 with ack delayed 3 cycles -> mem_req high 4 cycles, outputs stable.
  - With LSU_TIMEOUT_EN and TIMEOUT_CYC = 4, no ack -> rsp_err 1 after 4 REQ cycles.
- Reset asserted mid-REQ -> mem_req low before the next edge, no rsp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state type and request decode helpers for the LSU.
// Optional REQ-state timeout in lsu_mem_master is enabled by defining LSU_TIMEOUT_EN.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } lsu_state_t;

    function automatic logic legal(input logic we, input logic [2:0] f3);
        unique case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !we;
            default:          legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] off);
        unique case (f3)
            F3_H, F3_HU: misaligned = off[0];
            F3_W:        misaligned = |off;
            default:     misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        be_gen = 4'b1111;
        if (we) begin
            unique case (f3)
                F3_B:    be_gen = 4'b0001 << off;
                F3_H:    be_gen = 4'b0011 << off;
                default: be_gen = 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [31:0] wdata_gen(input logic [2:0]  f3,
                                              input logic [31:0] d);
        unique case (f3)
            F3_B:    wdata_gen = {4{d[7:0]}};
            F3_H:    wdata_gen = {2{d[15:0]}};
            default: wdata_gen = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/halfword from a memory word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[7:0];
        unique case (off)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            2'd3: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        unique case (funct3)
            F3_B:    data = {{24{b[7]}}, b};
            F3_BU:   data = {24'h0, b};
            F3_H:    data = {{16{h[15]}}, h};
            F3_HU:   data = {16'h0, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: decodes core ops into word req/ack memory cycles.
// Define LSU_TIMEOUT_EN to abort REQ after TIMEOUT_CYC cycles without mem_ack.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] ld_data;
    logic        accept;
    logic        bad;
    logic        tmo;

    assign accept = req_valid && (state_q == IDLE);
    assign bad    = !legal(req_we, req_funct3)
                  || misaligned(req_funct3, req_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (state_q == REQ && !mem_ack) begin
            cnt_q <= cnt_q + 8'd1;
        end else begin
            cnt_q <= 8'd0;
        end
    end

    // cnt_q counts completed REQ cycles; this is the last allowed one
    assign tmo = (cnt_q == 8'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYC;
    assign tmo = 1'b0;
`endif

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bad ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_ack || tmo) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            addr_q  <= {req_addr[31:2], 2'b00};
            be_q    <= be_gen(req_we, req_funct3, req_addr[1:0]);
            wdata_q <= req_we ? wdata_gen(req_funct3, req_wdata) : 32'h0;
            err_q   <= bad;
            rdata_q <= 32'h0;
        end else if (state_q == REQ) begin
            if (mem_ack) begin
                err_q   <= 1'b0;
                rdata_q <= we_q ? 32'h0 : ld_data;
            end else if (tmo) begin
                err_q   <= 1'b1;
                rdata_q <= 32'h0;
            end
        end
    end

    // Decoded from state so reset drops mem_req without waiting for an edge
    assign req_ready = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? addr_q : 32'h0;
    assign mem_be    = mem_req ? be_q : 4'h0;
    assign mem_wdata = mem_req ? wdata_q : 32'h0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err   = rsp_valid & err_q;

endmodule
